// File: rtl/leaf_bridge_pkg.sv
// Shared types for the leaf stream bridge.
// Run-control states and FIFO pointer sizing.
package leaf_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FLUSH
  } state_e;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/leaf_stream_fifo.sv
// Elastic single-clock FIFO, registered output, no fall-through.
// Flush zeroes pointers and occupancy in one cycle.
module leaf_stream_fifo
  import leaf_bridge_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS = 32,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    push,
  input  logic [PAYLOAD_BITS-1:0] din,
  output logic                    full,
  input  logic                    pop,
  output logic [PAYLOAD_BITS-1:0] dout,
  output logic                    empty
);

  localparam int PW = ptr_w(FIFO_DEPTH);

  logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]           wr_q;
  logic [PW-1:0]           rd_q;
  logic [PW:0]             cnt_q;
  logic                    push_ok;
  logic                    pop_ok;

  assign full    = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + PW'(1);
      if (pop_ok)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + (PW+1)'(push_ok)
                     - (PW+1)'(pop_ok);
    end
  end

  // Storage needs no reset: occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/leaf_stream_bridge.sv
// Bridges leaf_interface user ports to HLS kernel AXI streams
// with per-channel FIFOs, run control and per-run word counters.
module leaf_stream_bridge
  import leaf_bridge_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS = 32,
  parameter int unsigned N_IN         = 1,
  parameter int unsigned N_OUT        = 1,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned AUTO_START   = 1,
  parameter int unsigned CNT_BITS     = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ap_start,
  input  logic                          resend,
  output logic                          ap_done,
  input  logic [N_IN*PAYLOAD_BITS-1:0]  dout_leaf_interface2user,
  input  logic [N_IN-1:0]               vld_interface2user,
  output logic [N_IN-1:0]               ack_user2interface,
  output logic [N_OUT*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  output logic [N_OUT-1:0]              vld_user2interface,
  input  logic [N_OUT-1:0]              ack_interface2user,
  output logic [N_IN*PAYLOAD_BITS-1:0]  k_in_tdata,
  output logic [N_IN-1:0]               k_in_tvalid,
  input  logic [N_IN-1:0]               k_in_tready,
  input  logic [N_OUT*PAYLOAD_BITS-1:0] k_out_tdata,
  input  logic [N_OUT-1:0]              k_out_tvalid,
  output logic [N_OUT-1:0]              k_out_tready,
  output logic                          k_ap_start,
  input  logic                          k_ap_done,
  output logic                          k_ap_rst_n,
  output logic [CNT_BITS-1:0]           in_count,
  output logic [CNT_BITS-1:0]           out_count
);

  state_e state_q, state_d;
  logic   run;
  logic   flushing;

  logic [N_IN-1:0]  ig_full, ig_empty;
  logic [N_OUT-1:0] eg_full, eg_empty;

  logic [CNT_BITS-1:0] in_q, in_d;
  logic [CNT_BITS-1:0] out_q, out_d;
  logic [CNT_BITS:0]   in_sum, out_sum;
  logic [3:0]          n_in, n_out;

  assign run        = (state_q == ST_RUN);
  assign flushing   = (state_q == ST_FLUSH);
  assign k_ap_start = run;
  assign k_ap_rst_n = reset_n && !flushing;
  assign in_count   = in_q;
  assign out_count  = out_q;

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    logic [PAYLOAD_BITS-1:0] q;
    assign ack_user2interface[i] = !ig_full[i] && !flushing;
    assign k_in_tvalid[i]        = !ig_empty[i] && run;
    assign k_in_tdata[i*PAYLOAD_BITS +: PAYLOAD_BITS] =
      k_in_tvalid[i] ? q : '0;

    leaf_stream_fifo #(
      .PAYLOAD_BITS (PAYLOAD_BITS),
      .FIFO_DEPTH   (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flushing),
      .push    (vld_interface2user[i] && ack_user2interface[i]),
      .din     (dout_leaf_interface2user[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .full    (ig_full[i]),
      .pop     (k_in_tvalid[i] && k_in_tready[i]),
      .dout    (q),
      .empty   (ig_empty[i])
    );
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    logic [PAYLOAD_BITS-1:0] q;
    assign k_out_tready[j]       = !eg_full[j] && !flushing;
    assign vld_user2interface[j] = !eg_empty[j] && !flushing;
    assign din_leaf_user2interface[j*PAYLOAD_BITS +: PAYLOAD_BITS] =
      vld_user2interface[j] ? q : '0;

    leaf_stream_fifo #(
      .PAYLOAD_BITS (PAYLOAD_BITS),
      .FIFO_DEPTH   (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flushing),
      .push    (k_out_tvalid[j] && k_out_tready[j]),
      .din     (k_out_tdata[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .full    (eg_full[j]),
      .pop     (vld_user2interface[j] && ack_interface2user[j]),
      .dout    (q),
      .empty   (eg_empty[j])
    );
  end

  // resend outranks every other transition and suppresses ap_done
  always_comb begin
    state_d = state_q;
    ap_done = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (ap_start || (AUTO_START != 0)) state_d = ST_RUN;
      ST_RUN:   if (k_ap_done) state_d = ST_DRAIN;
      ST_DRAIN: if (&eg_empty) begin
        state_d = ST_IDLE;
        ap_done = 1'b1;
      end
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (resend) begin
      state_d = ST_FLUSH;
      ap_done = 1'b0;
    end
  end

  always_comb begin
    n_in  = '0;
    n_out = '0;
    for (int i = 0; i < N_IN; i++)
      n_in = n_in + 4'(k_in_tvalid[i] & k_in_tready[i]);
    for (int j = 0; j < N_OUT; j++)
      n_out = n_out + 4'(vld_user2interface[j] & ack_interface2user[j]);
    in_sum  = {1'b0, in_q} + (CNT_BITS+1)'(n_in);
    out_sum = {1'b0, out_q} + (CNT_BITS+1)'(n_out);
    in_d  = in_sum[CNT_BITS]  ? '1 : in_sum[CNT_BITS-1:0];
    out_d = out_sum[CNT_BITS] ? '1 : out_sum[CNT_BITS-1:0];
    if (state_q == ST_IDLE && state_d == ST_RUN) begin
      in_d  = '0;
      out_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      in_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_leaf_stream_bridge.sv
// Directed + randomized bench for leaf_stream_bridge.
// Loopback kernel, per-channel queue scoreboard.
module tb_leaf_stream_bridge;

  localparam int PB = 32;
  localparam int NI = 3;
  localparam int NO = 3;
  localparam int D  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n, ap_start, resend, ap_done;
  logic [NI*PB-1:0] din_u;
  logic [NI-1:0]    vld_in, ack_u2i;
  logic [NO*PB-1:0] dout_u;
  logic [NO-1:0]    vld_out, ack_i2u;
  logic [NI*PB-1:0] k_in_tdata;
  logic [NI-1:0]    k_in_tvalid, k_in_tready;
  logic [NO*PB-1:0] k_out_tdata;
  logic [NO-1:0]    k_out_tvalid, k_out_tready;
  logic             k_ap_start, k_ap_done, k_ap_rst_n;
  logic [31:0]      in_count, out_count;

  logic          loop_en;
  logic [NI-1:0] kst, vgate;

  assign k_out_tdata  = k_in_tdata;
  assign k_out_tvalid = loop_en ? (k_in_tvalid & ~kst) : '0;
  assign k_in_tready  = loop_en ? (k_out_tready & ~kst) : '0;

  leaf_stream_bridge #(
    .PAYLOAD_BITS (PB),
    .N_IN         (NI),
    .N_OUT        (NO),
    .FIFO_DEPTH   (D),
    .AUTO_START   (0),
    .CNT_BITS     (32)
  ) dut (
    .clk                      (clk),
    .reset_n                  (reset_n),
    .ap_start                 (ap_start),
    .resend                   (resend),
    .ap_done                  (ap_done),
    .dout_leaf_interface2user (din_u),
    .vld_interface2user       (vld_in),
    .ack_user2interface       (ack_u2i),
    .din_leaf_user2interface  (dout_u),
    .vld_user2interface       (vld_out),
    .ack_interface2user       (ack_i2u),
    .k_in_tdata               (k_in_tdata),
    .k_in_tvalid              (k_in_tvalid),
    .k_in_tready              (k_in_tready),
    .k_out_tdata              (k_out_tdata),
    .k_out_tvalid             (k_out_tvalid),
    .k_out_tready             (k_out_tready),
    .k_ap_start               (k_ap_start),
    .k_ap_done                (k_ap_done),
    .k_ap_rst_n               (k_ap_rst_n),
    .in_count                 (in_count),
    .out_count                (out_count)
  );

  logic [PB-1:0] src_q [NI][$];
  logic [PB-1:0] fly_q [NI][$];
  int total = 0;
  int bad   = 0;
  int m_in, m_out, rx, done_seen, acc;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int c = 0; c < NI; c++)
      s += src_q[c].size() + fly_q[c].size();
    return s;
  endfunction

  task automatic cyc();
    for (int c = 0; c < NI; c++) begin
      vld_in[c] = (src_q[c].size() > 0) && vgate[c];
      din_u[c*PB +: PB] = vld_in[c] ? src_q[c][0] : '0;
    end
    @(negedge clk);
    for (int c = 0; c < NI; c++) begin
      if (vld_in[c] && ack_u2i[c]) begin
        fly_q[c].push_back(src_q[c].pop_front());
        acc++;
      end
      if (k_in_tvalid[c] && k_in_tready[c]) m_in++;
      if (vld_out[c] && ack_i2u[c]) begin
        m_out++;
        rx++;
        if (fly_q[c].size() == 0)
          chk($sformatf("egress_extra%0d", c), 1, 0);
        else
          chk($sformatf("egress_data%0d", c),
              dout_u[c*PB +: PB], fly_q[c].pop_front());
      end
    end
    if (ap_done) done_seen++;
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    ap_start = 1'b1;
    cyc();
    ap_start = 1'b0;
    m_in  = 0;
    m_out = 0;
    chk("run_entry", k_ap_start, 1);
  endtask

  task automatic drain(int maxc);
    int n = 0;
    vgate   = '1;
    ack_i2u = '1;
    kst     = '0;
    while (pending() > 0 && n < maxc) begin
      cyc();
      n++;
    end
    chk("drain_left", pending(), 0);
  endtask

  task automatic clear_model();
    for (int c = 0; c < NI; c++) begin
      src_q[c].delete();
      fly_q[c].delete();
    end
  endtask

  initial begin
    int prev, rx_at;
    reset_n = 1'b0; ap_start = 1'b0; resend = 1'b0;
    k_ap_done = 1'b0; loop_en = 1'b1; kst = '0;
    vgate = '1; ack_i2u = '1; vld_in = '0; din_u = '0;
    m_in = 0; m_out = 0; rx = 0; done_seen = 0; acc = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ap_done", ap_done, 0);
    chk("rst_tvalid", k_in_tvalid, 0);
    chk("rst_vld", vld_out, 0);
    chk("rst_kstart", k_ap_start, 0);
    chk("rst_in_cnt", in_count, 0);
    chk("rst_out_cnt", out_count, 0);
    chk("rst_ack", ack_u2i, 3'b111);
    chk("rst_tready", k_out_tready, 3'b111);
    chk("rst_krst", k_ap_rst_n, 0);
    chk("rst_kdata", k_in_tdata, 0);
    chk("rst_dout", dout_u, 0);
    reset_n = 1'b1;
    #1;
    chk("krst_follow", k_ap_rst_n, 1);
    @(posedge clk);
    #1;

    // start gating: words wait in IDLE
    for (int k = 0; k < 3; k++) src_q[0].push_back(32'hA0 + k);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("gate_tvalid", k_in_tvalid, 0);
      chk("gate_ack", ack_u2i, 3'b111);
    end
    chk("gate_kstart", k_ap_start, 0);
    start_run();
    drain(20);
    chk("gate_in_cnt", in_count, 3);
    chk("gate_out_cnt", out_count, 3);

    // flow-through 0x1..0x10 on channel 0
    for (int k = 1; k <= 16; k++) src_q[0].push_back(k);
    drain(60);
    chk("flow_in_cnt", in_count, 19);
    chk("flow_out_cnt", out_count, 19);

    // multi-channel random stalls
    for (int c = 0; c < NI; c++)
      for (int k = 0; k < 20; k++)
        src_q[c].push_back(((c + 1) << 24) | k);
    for (int k = 0; k < 80; k++) begin
      vgate   = NI'($urandom);
      ack_i2u = NO'($urandom);
      kst     = NI'($urandom);
      cyc();
    end
    drain(200);
    chk("multi_in_cnt", in_count, 79);
    chk("multi_in_model", in_count, m_in);
    chk("multi_out_model", out_count, m_out);

    // full backpressure on channel 1
    loop_en = 1'b0;
    acc = 0;
    for (int k = 0; k < 6; k++) src_q[1].push_back(32'hB0 + k);
    for (int k = 0; k < 4; k++) cyc();
    chk("full_acc4", acc, 4);
    chk("full_ack_low", ack_u2i[1], 0);
    repeat (2) cyc();
    chk("full_hold", acc, 4);
    chk("full_left", src_q[1].size(), 2);
    loop_en = 1'b1;
    rx = 0;
    drain(40);
    chk("full_rx", rx, 6);

    // DRAIN and ap_done
    ack_i2u = '0;
    for (int k = 0; k < 3; k++) src_q[2].push_back(32'hC0 + k);
    repeat (8) cyc();
    chk("drain_queued", vld_out[2], 1);
    ack_i2u = '1;
    k_ap_done = 1'b1;
    rx = 0;
    done_seen = 0;
    rx_at = -1;
    cyc();
    k_ap_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      prev = done_seen;
      cyc();
      if (done_seen != prev && rx_at < 0) rx_at = rx;
    end
    chk("done_once", done_seen, 1);
    chk("done_after3", rx_at, 3);
    chk("done_idle", k_ap_start, 0);
    chk("done_empty", pending(), 0);

    // flush with FIFOs partly filled in RUN
    start_run();
    ack_i2u = '0;
    for (int k = 0; k < 2; k++) src_q[0].push_back(32'hD0 + k);
    repeat (5) cyc();
    loop_en = 1'b0;
    for (int k = 0; k < 2; k++) src_q[1].push_back(32'hE0 + k);
    repeat (3) cyc();
    chk("pre_flush_in", in_count, 2);
    resend = 1'b1;
    cyc();
    resend = 1'b0;
    clear_model();
    chk("fl_tvalid", k_in_tvalid, 0);
    chk("fl_vld", vld_out, 0);
    chk("fl_krst", k_ap_rst_n, 0);
    chk("fl_ack", ack_u2i, 0);
    chk("fl_tready", k_out_tready, 0);
    cyc();
    chk("fl_krst_back", k_ap_rst_n, 1);
    chk("fl_idle", k_ap_start, 0);
    chk("fl_keep_cnt", in_count, 2);
    loop_en = 1'b1;
    ack_i2u = '1;
    cyc();
    chk("fl_egress_empty", vld_out, 0);
    chk("fl_ingress_ack", ack_u2i, 3'b111);

    // resend coinciding with k_ap_done
    start_run();
    resend = 1'b1;
    k_ap_done = 1'b1;
    done_seen = 0;
    cyc();
    resend = 1'b0;
    k_ap_done = 1'b0;
    repeat (6) cyc();
    chk("rs_no_done", done_seen, 0);
    chk("rs_idle", k_ap_start, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/leaf_stream_bridge.md
# leaf_stream_bridge

Parametrised bridge between the packet-side `leaf_interface` user ports and an HLS kernel's AXI-stream ports inside a leaf wrapper. It carries `N_IN` input and `N_OUT` output channels, each with its own elastic FIFO. A run-control FSM drives the kernel's `ap_start` and reset and handles `resend` flushes. It also keeps per-run word counters. It generalises the fixed single-channel, always-started kernel hookup to any channel count, depth and start mode.

## Interface
- `PAYLOAD_BITS`, 32, width of one stream word
- `N_IN`, 1, channels from the interface to the kernel (1..8)
- `N_OUT`, 1, channels from the kernel to the interface (1..8)
- `FIFO_DEPTH`, 16, words per channel FIFO; power of two, ≥2
- `AUTO_START`, 1, 1 = enter RUN from IDLE without `ap_start`
- `CNT_BITS`, 32, width of each word counter

- `clk` in 1: single clock
- `reset_n` in 1: asynchronous, active-low reset
- `ap_start` in 1: run request (level)
- `resend` in 1: flush request
- `ap_done` out 1: one-cycle pulse at the end of DRAIN
- `dout_leaf_interface2user` in N_IN*PAYLOAD_BITS: ingress data
- `vld_interface2user` in N_IN: ingress valid
- `ack_user2interface` out N_IN: ingress ready
- `din_leaf_user2interface` out N_OUT*PAYLOAD_BITS: egress data
- `vld_user2interface` out N_OUT: egress valid
- `ack_interface2user` in N_OUT: egress ready
- `k_in_tdata` out N_IN*PAYLOAD_BITS, `k_in_tvalid` out N_IN, `k_in_tready` in N_IN: kernel input streams
- `k_out_tdata` in N_OUT*PAYLOAD_BITS, `k_out_tvalid` in N_OUT, `k_out_tready` out N_OUT: kernel output streams
- `k_ap_start` out 1, `k_ap_done` in 1, `k_ap_rst_n` out 1: kernel control
- `in_count` out CNT_BITS, `out_count` out CNT_BITS: words consumed by the kernel / words delivered to the interface this run

## Operation
- **Transfer rule:** every vld/ack and tvalid/tready pair moves one word on a rising edge where both are high. Channel i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
- **Ingress FIFO i:**
  - Written from the interface.
  - `ack_user2interface[i] = !full_i && state!=FLUSH`.
  - `k_in_tvalid[i] = !empty_i && state==RUN`.
- **Egress FIFO j:**
  - Written from the kernel.
  - `k_out_tready[j] = !full_j && state!=FLUSH`.
  - `vld_user2interface[j] = !empty_j && state!=FLUSH`. Egress keeps draining in IDLE and DRAIN.
- **FSM:** states IDLE, RUN, DRAIN, FLUSH; reset state is IDLE.
  - IDLE → RUN when `ap_start || AUTO_START`. On entry both counters clear.
  - RUN → DRAIN on `k_ap_done`.
  - DRAIN → IDLE when all egress FIFOs are empty. `ap_done` pulses in the transition cycle.
  - Any state → FLUSH when `resend`. FLUSH lasts exactly one cycle, empties every FIFO (pointers and counts zeroed), then goes to IDLE. Counters are not cleared by FLUSH.
- `k_ap_start = (state==RUN)`.
- `k_ap_rst_n = reset_n && state!=FLUSH`, so a flush also resets the kernel.
- **Counters:**
  - `in_count` increments once per cycle if any kernel-input transfer occurs, adding the number of channels transferring.
  - `out_count` does the same for egress interface transfers.
  - Both saturate at 2^CNT_BITS−1.

## Timing
- **Reset values:**
  - Outputs 0: `ap_done`, all tvalid/vld, `k_ap_start`, counters, data.
  - Outputs 1: `ack_user2interface`, `k_out_tready`.
  - `k_ap_rst_n` follows `reset_n`.
- **FIFO latency:** a word written at edge N is visible as valid after edge N. Latency is 1 cycle; there is no fall-through.
- **Full:** ready is low when count==FIFO_DEPTH, even if a pop occurs in the same cycle. Ready rises the cycle after the pop.
- **Simultaneous push and pop:** count unchanged, data order preserved. Pointers wrap modulo FIFO_DEPTH.
- **Priority:** `resend` overrides `k_ap_done` and `ap_start` in the same cycle. A `k_ap_done` arriving outside RUN is ignored.
- **Mid-operation reset:** asynchronous `reset_n` low clears all state immediately. Words in flight are lost.

## Structure
- **Package `leaf_bridge_pkg`:** state enum (IDLE, RUN, DRAIN, FLUSH) and a `clog2`-based pointer-width function.
- **Sub-module `leaf_stream_fifo`:**
  - Parameters: PAYLOAD_BITS, FIFO_DEPTH.
  - Ports: clk, reset_n, flush, push/din/full, pop/dout/empty.
  - Instantiated N_IN + N_OUT times via generate.
- Total RTL is about 250 lines.

## Test plan
- **Flow-through:** AUTO_START=1, N_IN=N_OUT=1, kernel loopback. Send words 0x1..0x10 → same order out; `in_count`=`out_count`=16.
- **Start gating:** AUTO_START=0, 3 words pushed with `ap_start`=0 → `k_in_tvalid` stays 0 and `ack` stays 1. Raise `ap_start` → RUN the next cycle, words delivered.
- **Full backpressure:** FIFO_DEPTH=4, `k_in_tready`=0, push 6 words → `ack` low after the 4th is accepted. Release → 4 words out, then the remaining 2.
- **DRAIN/done:** `k_ap_done` pulsed with 3 egress words queued and `ack_interface2user` high → 3 words out, then `ap_done` pulses once; state returns to IDLE.
- **Flush:** `resend` with FIFOs half-full in RUN → next cycle all valids 0 and `k_ap_rst_n` low for 1 cycle; IDLE afterwards; `resend` coinciding with `k_ap_done` → no `ap_done`.
- **Multi-channel:** N_IN=3, distinct patterns per channel with random stalls → per-channel order intact; `in_count` equals the total words across all channels.
